// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC pipeline.
// Used by the fetch stage and its IF/ID register.
package wisc_pkg;

    typedef logic [15:0] word_t;

    localparam word_t      NOP_INSTR = 16'h0800;
    localparam word_t      RESET_PC  = 16'h0000;
    localparam logic [4:0] OP_HALT   = 5'b00000;

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StDrop,
        StHalt
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc_inc;
        logic  valid;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+2 and valid bit.
// Control priority is reset > flush > hold > load; with no control asserted it keeps its value.
module ifid_reg
    import wisc_pkg::*;
#(
    parameter word_t NopInstr = NOP_INSTR
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  flush_i,
    input  logic  hold_i,
    input  word_t instr_i,
    input  word_t pc_inc_i,
    output word_t instr_o,
    output word_t pc_inc_o,
    output logic  valid_o
);

    localparam ifid_t Bubble = '{instr: NopInstr, pc_inc: 16'h0000, valid: 1'b0};

    ifid_t ifid_q, ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = Bubble;
        end else if (hold_i) begin
            ifid_d = ifid_q;
        end else if (load_i) begin
            ifid_d = '{instr: instr_i, pc_inc: pc_inc_i, valid: 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_q <= Bubble;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr_o  = ifid_q.instr;
    assign pc_inc_o = ifid_q.pc_inc;
    assign valid_o  = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: PC, multi-cycle imem handshake and IF/ID load.
// Handles decode stalls, downstream redirects and halt.
module fetch_stage
    import wisc_pkg::*;
#(
    parameter word_t ResetPc  = RESET_PC,
    parameter word_t NopInstr = NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] imem_addr_o,
    output logic        imem_rd_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        imem_done_i,
    input  logic        haz_stall_i,
    input  logic        halt_id_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic [15:0] ifid_instr_o,
    output logic [15:0] ifid_pc_inc_o,
    output logic        ifid_valid_o,
    output logic        fetch_busy_o
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_q, pend_d;
    word_t        tgt_q, tgt_d;
    logic         drop_halt_q, drop_halt_d;

    logic  req_open;
    logic  ifid_load, ifid_flush, ifid_hold;
    word_t ifid_instr_d, ifid_pc_inc_d;
    word_t pc_inc;

    assign pc_inc   = pc_q + 16'd2;
    assign req_open = (state_q == StFetch) || (state_q == StDrop);

    // Request outputs depend only on state and pc; reset gates them off.
    assign imem_addr_o  = pc_q;
    assign imem_rd_o    = req_open && !rst_i;
    assign fetch_busy_o = !rst_i &&
                          (((state_q == StFetch) && !imem_done_i) || (state_q == StDrop));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        tgt_d         = tgt_q;
        drop_halt_d   = drop_halt_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_hold     = 1'b0;
        ifid_instr_d  = imem_rdata_i;
        ifid_pc_inc_d = pc_inc;

        if (redirect_i) begin
            ifid_flush = 1'b1;
            pend_d     = NopInstr;
            if (req_open && !imem_done_i) begin
                // Open request must complete before the new address can be issued.
                tgt_d       = redirect_pc_i;
                drop_halt_d = 1'b0;
                state_d     = StDrop;
            end else begin
                pc_d    = redirect_pc_i;
                state_d = StFetch;
            end
        end else if (halt_id_i) begin
            ifid_flush = 1'b1;
            pend_d     = NopInstr;
            if (req_open && !imem_done_i) begin
                drop_halt_d = 1'b1;
                state_d     = StDrop;
            end else begin
                state_d = StHalt;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_done_i) begin
                        pc_d = pc_inc;
                        if (haz_stall_i) begin
                            pend_d    = imem_rdata_i;
                            ifid_hold = 1'b1;
                            state_d   = StHold;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (haz_stall_i) begin
                        ifid_hold = 1'b1;
                    end else begin
                        ifid_flush = 1'b1;
                    end
                end
                StHold: begin
                    // pc already advanced past the pended word, so it is that word's PC+2.
                    ifid_instr_d  = pend_q;
                    ifid_pc_inc_d = pc_q;
                    if (haz_stall_i) begin
                        ifid_hold = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                        state_d   = StFetch;
                    end
                end
                StDrop: begin
                    if (haz_stall_i) begin
                        ifid_hold = 1'b1;
                    end else begin
                        ifid_flush = 1'b1;
                    end
                    if (imem_done_i) begin
                        if (drop_halt_q) begin
                            state_d = StHalt;
                        end else begin
                            pc_d    = tgt_q;
                            state_d = StFetch;
                        end
                    end
                end
                StHalt: begin
                    ifid_flush = 1'b1;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFetch;
            pc_q        <= ResetPc;
            pend_q      <= NopInstr;
            tgt_q       <= ResetPc;
            drop_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            tgt_q       <= tgt_d;
            drop_halt_q <= drop_halt_d;
        end
    end

    ifid_reg #(
        .NopInstr (NopInstr)
    ) u_ifid_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load),
        .flush_i  (ifid_flush),
        .hold_i   (ifid_hold),
        .instr_i  (ifid_instr_d),
        .pc_inc_i (ifid_pc_inc_d),
        .instr_o  (ifid_instr_o),
        .pc_inc_o (ifid_pc_inc_o),
        .valid_o  (ifid_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scripted imem responses per scenario,
// expected IF/ID contents queued at drive time and compared after the clock edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, ifid_instr, ifid_pc_inc;
    logic        imem_rd, imem_done, haz_stall, halt_id, redirect, ifid_valid, fetch_busy;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        logic        done;
        logic [15:0] rdata;
        logic        stall;
        logic        halt;
        logic        redir;
        logic [15:0] rpc;
        logic        rd;
        logic [15:0] addr;
        logic        busy;
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        valid;
    } step_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        valid;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_addr_o   (imem_addr),
        .imem_rd_o     (imem_rd),
        .imem_rdata_i  (imem_rdata),
        .imem_done_i   (imem_done),
        .haz_stall_i   (haz_stall),
        .halt_id_i     (halt_id),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ifid_instr_o  (ifid_instr),
        .ifid_pc_inc_o (ifid_pc_inc),
        .ifid_valid_o  (ifid_valid),
        .fetch_busy_o  (fetch_busy)
    );

    function automatic step_t st(input logic d, input logic [15:0] rdata, input logic s,
                                 input logic h, input logic r, input logic [15:0] rpc,
                                 input logic rd, input logic [15:0] addr, input logic busy,
                                 input logic [15:0] instr, input logic [15:0] pc_inc,
                                 input logic v);
        step_t x;
        x = '{d, rdata, s, h, r, rpc, rd, addr, busy, instr, pc_inc, v};
        return x;
    endfunction

    task automatic apply(input step_t s);
        imem_done   = s.done;
        imem_rdata  = s.rdata;
        haz_stall   = s.stall;
        halt_id     = s.halt;
        redirect    = s.redir;
        redirect_pc = s.rpc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(st(0, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0, 0, NOP, 16'h0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (imem_rd !== 1'b0) $display("FAIL reset_rd got %b want 0", imem_rd);
        else n_pass++;
        n_total++;
        if (fetch_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", fetch_busy);
        else n_pass++;
        n_total++;
        if (ifid_instr !== NOP) $display("FAIL reset_instr got %h want %h", ifid_instr, NOP);
        else n_pass++;
        n_total++;
        if (ifid_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ifid_valid);
        else n_pass++;
        n_total++;
        if (ifid_pc_inc !== 16'h0) $display("FAIL reset_pc_inc got %h want 0000", ifid_pc_inc);
        else n_pass++;
    endtask

    task automatic test_hit_stream();
        step_t tbl[$];
        exp_t  e;
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(st(1, 16'h4000 + 16'(2 * i), 0, 0, 0, 16'h0, 1, 16'(2 * i), 0,
                             16'h4000 + 16'(2 * i), 16'(2 * i + 2), 1));
        end
        rst = 1'b0;
        foreach (tbl[i]) begin
            apply(tbl[i]);
            n_total++;
            if ({imem_rd, fetch_busy, imem_addr} !== {tbl[i].rd, tbl[i].busy, tbl[i].addr})
                $display("FAIL hit_bus[%0d] rd/busy/addr got %b/%b/%h want %b/%b/%h", i,
                         imem_rd, fetch_busy, imem_addr, tbl[i].rd, tbl[i].busy, tbl[i].addr);
            else n_pass++;
            sb.push_back('{tbl[i].instr, tbl[i].pc_inc, tbl[i].valid});
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if ({ifid_valid, ifid_instr, ifid_pc_inc} !== {e.valid, e.instr, e.pc_inc})
                $display("FAIL hit_ifid[%0d] v/instr/pc_inc got %b/%h/%h want %b/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc_inc, e.valid, e.instr, e.pc_inc);
            else n_pass++;
        end
    endtask

    // Generic scenario runner body is repeated per test so each owns its comparisons.
    task automatic test_miss();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st(0, 16'h0,    0, 0, 0, 16'h0, 1, 16'h0010, 1, NOP,      16'h0,    0));
        tbl.push_back(st(0, 16'h0,    0, 0, 0, 16'h0, 1, 16'h0010, 1, NOP,      16'h0,    0));
        tbl.push_back(st(1, 16'h4010, 0, 0, 0, 16'h0, 1, 16'h0010, 0, 16'h4010, 16'h0012, 1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            n_total++;
            if ({imem_rd, fetch_busy, imem_addr} !== {tbl[i].rd, tbl[i].busy, tbl[i].addr})
                $display("FAIL miss_bus[%0d] rd/busy/addr got %b/%b/%h want %b/%b/%h", i,
                         imem_rd, fetch_busy, imem_addr, tbl[i].rd, tbl[i].busy, tbl[i].addr);
            else n_pass++;
            sb.push_back('{tbl[i].instr, tbl[i].pc_inc, tbl[i].valid});
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if ({ifid_valid, ifid_instr, ifid_valid ? ifid_pc_inc : 16'h0} !==
                {e.valid, e.instr, e.valid ? e.pc_inc : 16'h0})
                $display("FAIL miss_ifid[%0d] v/instr/pc_inc got %b/%h/%h want %b/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc_inc, e.valid, e.instr, e.pc_inc);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1, 16'h4012, 1, 0, 0, 16'h0, 1, 16'h0012, 0, 16'h4010, 16'h0012, 1));
        tbl.push_back(st(0, 16'h0,    1, 0, 0, 16'h0, 0, 16'h0,    0, 16'h4010, 16'h0012, 1));
        tbl.push_back(st(0, 16'h0,    0, 0, 0, 16'h0, 0, 16'h0,    0, 16'h4012, 16'h0014, 1));
        tbl.push_back(st(1, 16'h4014, 0, 0, 0, 16'h0, 1, 16'h0014, 0, 16'h4014, 16'h0016, 1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            n_total++;
            if ({imem_rd, fetch_busy, imem_rd ? imem_addr : 16'h0} !==
                {tbl[i].rd, tbl[i].busy, tbl[i].addr})
                $display("FAIL stall_bus[%0d] rd/busy/addr got %b/%b/%h want %b/%b/%h", i,
                         imem_rd, fetch_busy, imem_addr, tbl[i].rd, tbl[i].busy, tbl[i].addr);
            else n_pass++;
            sb.push_back('{tbl[i].instr, tbl[i].pc_inc, tbl[i].valid});
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if ({ifid_valid, ifid_instr, ifid_pc_inc} !== {e.valid, e.instr, e.pc_inc})
                $display("FAIL stall_ifid[%0d] v/instr/pc_inc got %b/%h/%h want %b/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc_inc, e.valid, e.instr, e.pc_inc);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st(0, 16'h0,    0, 0, 0, 16'h0,    1, 16'h0016, 1, NOP,      16'h0, 0));
        tbl.push_back(st(0, 16'h0,    1, 0, 1, 16'h0200, 1, 16'h0016, 1, NOP,      16'h0, 0));
        tbl.push_back(st(0, 16'h0,    0, 0, 1, 16'h0100, 1, 16'h0016, 1, NOP,      16'h0, 0));
        tbl.push_back(st(1, 16'hDEAD, 0, 0, 0, 16'h0,    1, 16'h0016, 1, NOP,      16'h0, 0));
        tbl.push_back(st(1, 16'h4100, 0, 0, 0, 16'h0,    1, 16'h0100, 0, 16'h4100, 16'h0102, 1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            n_total++;
            if ({imem_rd, fetch_busy, imem_addr} !== {tbl[i].rd, tbl[i].busy, tbl[i].addr})
                $display("FAIL redir_bus[%0d] rd/busy/addr got %b/%b/%h want %b/%b/%h", i,
                         imem_rd, fetch_busy, imem_addr, tbl[i].rd, tbl[i].busy, tbl[i].addr);
            else n_pass++;
            sb.push_back('{tbl[i].instr, tbl[i].pc_inc, tbl[i].valid});
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if ({ifid_valid, ifid_instr, ifid_valid ? ifid_pc_inc : 16'h0} !==
                {e.valid, e.instr, e.valid ? e.pc_inc : 16'h0})
                $display("FAIL redir_ifid[%0d] v/instr/pc_inc got %b/%h/%h want %b/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc_inc, e.valid, e.instr, e.pc_inc);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1, 16'h4102, 0, 0, 0, 16'h0,    1, 16'h0102, 0, 16'h4102, 16'h0104, 1));
        tbl.push_back(st(0, 16'h0,    0, 1, 0, 16'h0,    1, 16'h0104, 1, NOP,      16'h0,    0));
        tbl.push_back(st(1, 16'hBEEF, 0, 0, 0, 16'h0,    1, 16'h0104, 1, NOP,      16'h0,    0));
        tbl.push_back(st(1, 16'h0,    0, 1, 0, 16'h0,    0, 16'h0,    0, NOP,      16'h0,    0));
        tbl.push_back(st(0, 16'h0,    0, 0, 0, 16'h0,    0, 16'h0,    0, NOP,      16'h0,    0));
        tbl.push_back(st(0, 16'h0,    0, 0, 1, 16'h0040, 0, 16'h0,    0, NOP,      16'h0,    0));
        tbl.push_back(st(1, 16'h4040, 0, 0, 0, 16'h0,    1, 16'h0040, 0, 16'h4040, 16'h0042, 1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            n_total++;
            if ({imem_rd, fetch_busy, imem_rd ? imem_addr : 16'h0} !==
                {tbl[i].rd, tbl[i].busy, tbl[i].addr})
                $display("FAIL halt_bus[%0d] rd/busy/addr got %b/%b/%h want %b/%b/%h", i,
                         imem_rd, fetch_busy, imem_addr, tbl[i].rd, tbl[i].busy, tbl[i].addr);
            else n_pass++;
            sb.push_back('{tbl[i].instr, tbl[i].pc_inc, tbl[i].valid});
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if ({ifid_valid, ifid_instr, ifid_valid ? ifid_pc_inc : 16'h0} !==
                {e.valid, e.instr, e.valid ? e.pc_inc : 16'h0})
                $display("FAIL halt_ifid[%0d] v/instr/pc_inc got %b/%h/%h want %b/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc_inc, e.valid, e.instr, e.pc_inc);
            else n_pass++;
        end
    endtask

    task automatic test_pc_wrap();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(st(1, 16'h1234, 0, 0, 1, 16'hFFFE, 1, 16'h0042, 0, NOP,      16'h0,    0));
        tbl.push_back(st(1, 16'h3FFE, 0, 0, 0, 16'h0,    1, 16'hFFFE, 0, 16'h3FFE, 16'h0000, 1));
        tbl.push_back(st(1, 16'h4000, 0, 0, 0, 16'h0,    1, 16'h0000, 0, 16'h4000, 16'h0002, 1));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            n_total++;
            if ({imem_rd, fetch_busy, imem_addr} !== {tbl[i].rd, tbl[i].busy, tbl[i].addr})
                $display("FAIL wrap_bus[%0d] rd/busy/addr got %b/%b/%h want %b/%b/%h", i,
                         imem_rd, fetch_busy, imem_addr, tbl[i].rd, tbl[i].busy, tbl[i].addr);
            else n_pass++;
            sb.push_back('{tbl[i].instr, tbl[i].pc_inc, tbl[i].valid});
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            n_total++;
            if ({ifid_valid, ifid_instr, ifid_valid ? ifid_pc_inc : 16'h0} !==
                {e.valid, e.instr, e.valid ? e.pc_inc : 16'h0})
                $display("FAIL wrap_ifid[%0d] v/instr/pc_inc got %b/%h/%h want %b/%h/%h", i,
                         ifid_valid, ifid_instr, ifid_pc_inc, e.valid, e.instr, e.pc_inc);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_hit_stream();
        test_miss();
        test_stall();
        test_redirect();
        test_halt();
        test_pc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
